// File: rtl/pipe_mem_ctrl_pkg.sv
// Shared definitions for the pipeline memory controller: arbiter state
// encoding and the pipeline stall vectors (bit0 PC .. bit5 WB).
package pipe_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam int unsigned WDOG_W = 10;
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

endpackage

// File: rtl/pipe_mem_ctrl_bus_watchdog.sv
// Bus watchdog: counts cycles an access waits for ram_ack and raises a
// sticky error once the wait reaches the saturation value.
module bus_watchdog
  import pipe_mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_bus_err
);

  logic [WDOG_W-1:0] r_cnt;
  logic [WDOG_W-1:0] w_cnt_nxt;
  logic              r_bus_err;

  // Next wait count: clear when idle or acked, otherwise saturating increment.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_busy && !i_ack) begin
      w_cnt_nxt = (r_cnt == WDOG_MAX) ? WDOG_MAX : r_cnt + 1'b1;
    end
  end

  // Counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == WDOG_MAX) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign o_bus_err = r_bus_err;

endmodule

// File: rtl/pipe_mem_ctrl.sv
// Arbitrates a single RAM port between instruction fetch and data memory
// access, and produces the pipeline stall/flush controls.
module pipe_mem_ctrl
  import pipe_mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        flush_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        bus_err
);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic        r_if_discard;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic        w_busy;
  logic        w_fetch_ack;
  logic        w_data_ack;
  logic        w_discard_now;
  logic        w_mem_pending;
  logic        w_if_pending;

  assign w_busy      = (r_state == ST_FETCH) || (r_state == ST_DATA);
  assign w_fetch_ack = (r_state == ST_FETCH) && ram_ack;
  assign w_data_ack  = (r_state == ST_DATA) && ram_ack;
  // A flush or a dropped request in this very cycle also kills the fetch result.
  assign w_discard_now = r_if_discard ||
                         ((r_state == ST_FETCH) && (flush_req || !if_req));

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbiter next state: data access wins over fetch when both request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_req) begin
          w_state_nxt = ST_DATA;
        end else if (if_req) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: if (ram_ack) w_state_nxt = ST_IDLE;
      ST_DATA:  if (ram_ack) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the granted request on leaving IDLE; held until the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (mem_req) begin
        r_we    <= mem_we;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_sel   <= mem_sel;
      end else if (if_req) begin
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_wdata <= '0;
        r_sel   <= 4'hF;
      end
    end
  end

  // Discard marker for an in-flight fetch that was flushed or abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_discard <= 1'b0;
    end else if (r_state == ST_FETCH) begin
      if (ram_ack) begin
        r_if_discard <= 1'b0;
      end else if (flush_req || !if_req) begin
        r_if_discard <= 1'b1;
      end
    end else begin
      r_if_discard <= 1'b0;
    end
  end

  assign ram_req   = w_busy && !rst;
  assign ram_we    = (r_state == ST_DATA) && r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_sel   = r_sel;

  assign if_valid  = w_fetch_ack && !w_discard_now && !rst;
  assign if_rdata  = if_valid ? ram_rdata : 32'h0000_0000;
  assign mem_valid = w_data_ack && !rst;
  assign mem_rdata = mem_valid ? ram_rdata : 32'h0000_0000;

  assign w_mem_pending = mem_req && !w_data_ack;
  assign w_if_pending  = if_req && !w_fetch_ack && !r_if_discard;
  assign flush         = flush_req && !rst;

  // Stall priority encoder; a flush overrides every stall source.
  always_comb begin
    stall = STALL_NONE;
    if (!rst && !flush_req) begin
      if (w_mem_pending) begin
        stall = STALL_MEM;
      end else if (stallreq_ex) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end else if (w_if_pending) begin
        stall = STALL_IF;
      end
    end
  end

  bus_watchdog u_bus_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_busy    (w_busy),
    .i_ack     (ram_ack),
    .o_bus_err (bus_err)
  );

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed bench for pipe_mem_ctrl with hand-computed expectations.
module tb_pipe_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        flush_req;
  logic [5:0]  stall;
  logic        flush;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_sel     (mem_sel),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_sel     (ram_sel),
    .ram_rdata   (ram_rdata),
    .ram_ack     (ram_ack),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .flush_req   (flush_req),
    .stall       (stall),
    .flush       (flush),
    .bus_err     (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // settle before being sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_sel = '0; ram_rdata = '0; ram_ack = 1'b0;
    stallreq_id = 1'b0; stallreq_ex = 1'b0; flush_req = 1'b0;

    // Reset holds everything quiet even with live requests.
    tick(); tick();
    mem_req = 1'b1; flush_req = 1'b1; stallreq_ex = 1'b1; settle();
    check("rst_ram_req", {31'b0, ram_req}, 32'd0);
    check("rst_stall", {26'b0, stall}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    mem_req = 1'b0; flush_req = 1'b0; stallreq_ex = 1'b0;
    tick(); rst = 1'b0;

    // Single fetch, ack on third FETCH cycle.
    if_req = 1'b1; if_addr = 32'h0000_0100; settle();
    check("f_idle_stall", {26'b0, stall}, 32'b000011);
    check("f_idle_req", {31'b0, ram_req}, 32'd0);
    tick();
    check("f1_req", {31'b0, ram_req}, 32'd1);
    check("f1_addr", ram_addr, 32'h0000_0100);
    check("f1_we", {31'b0, ram_we}, 32'd0);
    check("f1_stall", {26'b0, stall}, 32'b000011);
    tick();
    check("f2_stall", {26'b0, stall}, 32'b000011);
    check("f2_valid", {31'b0, if_valid}, 32'd0);
    tick();
    ram_ack = 1'b1; ram_rdata = 32'h2401_0001; settle();
    check("f3_valid", {31'b0, if_valid}, 32'd1);
    check("f3_rdata", if_rdata, 32'h2401_0001);
    check("f3_stall", {26'b0, stall}, 32'd0);
    check("f3_we", {31'b0, ram_we}, 32'd0);
    tick();
    ram_ack = 1'b0; if_req = 1'b0; settle();
    check("f_done_req", {31'b0, ram_req}, 32'd0);

    // Simultaneous requests: data first, then fetch.
    if_req = 1'b1; if_addr = 32'h0000_0104;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_1000;
    mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF; settle();
    check("both_idle_stall", {26'b0, stall}, 32'b011111);
    tick();
    check("both_d_req", {31'b0, ram_req}, 32'd1);
    check("both_d_we", {31'b0, ram_we}, 32'd1);
    check("both_d_addr", ram_addr, 32'h0000_1000);
    check("both_d_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("both_d_sel", {28'b0, ram_sel}, 32'hF);
    check("both_d_stall", {26'b0, stall}, 32'b011111);
    ram_ack = 1'b1; ram_rdata = 32'h0000_0055; settle();
    check("both_d_valid", {31'b0, mem_valid}, 32'd1);
    check("both_d_ack_stall", {26'b0, stall}, 32'b000011);
    check("both_d_ifvalid", {31'b0, if_valid}, 32'd0);
    tick();
    ram_ack = 1'b0; mem_req = 1'b0; mem_we = 1'b0; settle();
    check("both_gap_req", {31'b0, ram_req}, 32'd0);
    check("both_gap_stall", {26'b0, stall}, 32'b000011);
    tick();
    check("both_f_addr", ram_addr, 32'h0000_0104);
    check("both_f_we", {31'b0, ram_we}, 32'd0);
    check("both_f_stall", {26'b0, stall}, 32'b000011);
    ram_ack = 1'b1; ram_rdata = 32'h1234_5678; settle();
    check("both_f_valid", {31'b0, if_valid}, 32'd1);
    check("both_f_rdata", if_rdata, 32'h1234_5678);
    tick();
    ram_ack = 1'b0; if_req = 1'b0; settle();

    // Flush during fetch: result discarded, next fetch served normally.
    if_req = 1'b1; if_addr = 32'h0000_0200; settle();
    tick();
    flush_req = 1'b1; settle();
    check("fl_flush", {31'b0, flush}, 32'd1);
    check("fl_stall", {26'b0, stall}, 32'd0);
    tick();
    flush_req = 1'b0; settle();
    check("fl_wait_stall", {26'b0, stall}, 32'd0);
    check("fl_wait_req", {31'b0, ram_req}, 32'd1);
    tick();
    ram_ack = 1'b1; ram_rdata = 32'hBAD0_BAD0; settle();
    check("fl_ack_valid", {31'b0, if_valid}, 32'd0);
    tick();
    ram_ack = 1'b0; if_addr = 32'h0000_0300; settle();
    check("fl_idle_req", {31'b0, ram_req}, 32'd0);
    check("fl_idle_stall", {26'b0, stall}, 32'b000011);
    tick();
    check("fl_next_addr", ram_addr, 32'h0000_0300);
    ram_ack = 1'b1; ram_rdata = 32'h1111_2222; settle();
    check("fl_next_valid", {31'b0, if_valid}, 32'd1);
    check("fl_next_rdata", if_rdata, 32'h1111_2222);
    tick();
    ram_ack = 1'b0; if_req = 1'b0; settle();

    // Hazard stalls without memory traffic.
    stallreq_id = 1'b1; stallreq_ex = 1'b1; settle();
    check("hz_ex", {26'b0, stall}, 32'b001111);
    stallreq_ex = 1'b0; settle();
    check("hz_id", {26'b0, stall}, 32'b000111);
    stallreq_id = 1'b0; settle();
    check("hz_none", {26'b0, stall}, 32'd0);

    // Data access starved of ack: watchdog trips after 1023 wait cycles.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2000; settle();
    tick();
    check("wd_req", {31'b0, ram_req}, 32'd1);
    repeat (1022) tick();
    check("wd_before", {31'b0, bus_err}, 32'd0);
    tick();
    check("wd_trip", {31'b0, bus_err}, 32'd1);
    repeat (77) tick();
    check("wd_still_req", {31'b0, ram_req}, 32'd1);
    check("wd_hold", {31'b0, bus_err}, 32'd1);
    ram_ack = 1'b1; ram_rdata = 32'h0000_00AA; settle();
    check("wd_ack_valid", {31'b0, mem_valid}, 32'd1);
    check("wd_ack_rdata", mem_rdata, 32'h0000_00AA);
    tick();
    ram_ack = 1'b0; mem_req = 1'b0; settle();
    check("wd_sticky", {31'b0, bus_err}, 32'd1);
    rst = 1'b1; tick();
    check("wd_cleared", {31'b0, bus_err}, 32'd0);
    rst = 1'b0; settle();

    // Reset in the middle of a data access; late ack ignored.
    mem_req = 1'b1; mem_addr = 32'h0000_3000; settle();
    tick();
    check("ra_req", {31'b0, ram_req}, 32'd1);
    rst = 1'b1; settle();
    check("ra_rst_req", {31'b0, ram_req}, 32'd0);
    check("ra_rst_stall", {26'b0, stall}, 32'd0);
    tick();
    rst = 1'b0; mem_req = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h5555_5555; settle();
    check("ra_late_req", {31'b0, ram_req}, 32'd0);
    check("ra_late_valid", {31'b0, mem_valid}, 32'd0);
    check("ra_late_addr", ram_addr, 32'd0);
    tick();
    ram_ack = 1'b0; settle();
    check("ra_idle_req", {31'b0, ram_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mem_ctrl.md
PIPE_MEM_CTRL -- requirements
Module: pipe_mem_ctrl

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL provide IF port: if_req in 1 fetch request; if_addr in 32 fetch address; if_rdata out 32 fetched word; if_valid out 1 fetch complete.
REQ-003 SHALL provide MEM port: mem_req in 1; mem_we in 1; mem_addr in 32; mem_wdata in 32; mem_sel in 4 byte enables; mem_rdata out 32; mem_valid out 1.
REQ-004 SHALL provide RAM port: ram_req out 1; ram_we out 1; ram_addr out 32; ram_wdata out 32; ram_sel out 4; ram_rdata in 32; ram_ack in 1.
REQ-005 SHALL provide control: stallreq_id in 1 load-use hazard; stallreq_ex in 1 multi-cycle EX op; flush_req in 1 exception flush; stall out 6 (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB); flush out 1; bus_err out 1 sticky timeout flag.

Function
REQ-006 SHALL arbitrate the single RAM port between IF and MEM with an FSM: IDLE, FETCH, DATA.
REQ-007 IDLE: mem_req -> DATA; else if_req -> FETCH; MEM wins when both asserted the same cycle.
REQ-008 Address/data/we/sel of the granted requester SHALL be registered on the IDLE->FETCH/DATA edge and held stable until ram_ack; ram_we forced 0 in FETCH.
REQ-009 ram_req SHALL equal 1 exactly when state is FETCH or DATA.
REQ-010 On ram_ack in FETCH: if_valid=1 and if_rdata=ram_rdata that same cycle, next state IDLE; likewise mem_valid/mem_rdata in DATA.
REQ-011 Minimum access latency SHALL be 1 cycle from request sample to valid (ack in first FETCH/DATA cycle); no upper bound on ram_ack.
REQ-012 mem_pending = mem_req & !(state==DATA & ram_ack); if_pending = if_req & !(state==FETCH & ram_ack) & !if_discard.
REQ-013 stall SHALL be the highest of: mem_pending -> 6'b011111; stallreq_ex -> 6'b001111; stallreq_id -> 6'b000111; if_pending -> 6'b000011; else 6'b000000.
REQ-014 flush SHALL equal flush_req combinationally; while flush_req=1, stall SHALL be 6'b000000.
REQ-015 flush_req in FETCH SHALL set if_discard; RAM access still completes but if_valid is suppressed for it; if_discard clears on that ack.
REQ-016 flush_req in DATA SHALL NOT cancel the access; mem_valid still reported on ack.
REQ-017 A 10-bit wait counter SHALL count cycles in FETCH/DATA without ack, clear on ack or IDLE, saturate at 1023; reaching 1023 SHALL set bus_err, held until reset; FSM keeps waiting.
REQ-018 if_req deasserted while in FETCH SHALL not abort the access; result discarded as in REQ-015.

Reset
REQ-019 rst SHALL force state IDLE, if_discard 0, wait counter 0, bus_err 0, held address/data/we/sel 0.
REQ-020 During rst: ram_req, if_valid, mem_valid, flush 0; stall 6'b000000; rdata outputs 32'h00000000.
REQ-021 rst mid-access SHALL abandon it; a late ram_ack after reset SHALL be ignored in IDLE.

Structure
REQ-022 Shared package SHALL hold FSM state encoding and stall vector constants (STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM).
REQ-023 Stall priority encoder SHALL be combinational in the top module; wait counter/timeout a sub-module named bus_watchdog.

Verification
REQ-024 if_req=1 if_addr=32'h00000100, ram_ack 3 cycles after ram_req, ram_rdata=32'h24010001 -> stall=000011 until ack cycle; if_valid=1 with that data; ram_we=0.
REQ-025 if_req and mem_req (we=1, addr=32'h00001000, wdata=32'hDEADBEEF, sel=4'hF) same cycle -> DATA first, stall=011111, ram_we=1; then FETCH, stall=000011.
REQ-026 flush_req pulse during FETCH, ack 2 cycles later -> flush=1 and stall=0 that cycle; no if_valid on that ack; next if_req served normally.
REQ-027 stallreq_id=1 and stallreq_ex=1, no memory traffic -> stall=001111; only stallreq_id -> 000111.
REQ-028 DATA with ram_ack held 0 for 1100 cycles -> bus_err rises at 1023rd wait cycle, stays 1 after ack; cleared only by rst.
REQ-029 rst in DATA, ram_ack next cycle -> state IDLE, mem_valid=0, ram_req=0.
